// File: rtl/rtc_edit_sequencer.sv
// RTC field edit sequencer.
// Walks the nine calendar/alarm fields, loading each from the register bank,
// letting the user step it in BCD with up/down buttons, and writing it back
// with a request/acknowledge handshake and a timeout.
// Optional feature: define AUTO_REPEAT_EN to enable hold-to-repeat on up/down.
module rtc_edit_sequencer #(
    parameter int unsigned REPEAT_DLY  = 4,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       edit_i,
    input  logic       next_i,
    input  logic       up_i,
    input  logic       down_i,
    input  logic       tick_i,
    input  logic [7:0] rd_data_i,
    input  logic       wr_ack_i,
    output logic [3:0] field_o,
    output logic [7:0] value_o,
    output logic [3:0] rd_addr_o,
    output logic [3:0] wr_addr_o,
    output logic [7:0] wr_data_o,
    output logic       wr_req_o,
    output logic       busy_o,
    output logic       err_o
);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StEdit,
        StWrite,
        StWaitAck
    } state_e;

    // Timeout counter holds 0 .. ACK_TIMEOUT-1
    localparam int unsigned TmoW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);

    localparam logic [3:0] LastField = 4'd9;

    // ------------------------------------------------------------------
    // Field range tables (packed BCD)
    // ------------------------------------------------------------------
    function automatic logic [7:0] fld_min(input logic [3:0] f);
        logic [7:0] m;
        case (f)
            4'd4, 4'd5: m = 8'h01;
            default:    m = 8'h00;
        endcase
        return m;
    endfunction

    function automatic logic [7:0] fld_max(input logic [3:0] f);
        logic [7:0] m;
        case (f)
            4'd1, 4'd2, 4'd8, 4'd9: m = 8'h59;
            4'd3, 4'd7:             m = 8'h23;
            4'd4:                   m = 8'h31;
            4'd5:                   m = 8'h12;
            4'd6:                   m = 8'h99;
            default:                m = 8'h00;
        endcase
        return m;
    endfunction

    // Packed BCD orders the same as its decimal value, so plain compares work
    function automatic logic [7:0] sanitize(input logic [7:0] v, input logic [3:0] f);
        logic [7:0] r;
        if (v[7:4] > 4'd9 || v[3:0] > 4'd9 || v < fld_min(f) || v > fld_max(f)) begin
            r = fld_min(f);
        end else begin
            r = v;
        end
        return r;
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [3:0] f);
        logic [7:0] r;
        if (v >= fld_max(f)) begin
            r = fld_min(f);
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [3:0] f);
        logic [7:0] r;
        if (v <= fld_min(f)) begin
            r = fld_max(f);
        end else if (v[3:0] == 4'd0) begin
            r = {v[7:4] - 4'd1, 4'd9};
        end else begin
            r = {v[7:4], v[3:0] - 4'd1};
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e          r_state;
    logic [3:0]      r_field;
    logic [7:0]      r_value;
    logic [3:0]      r_rd_addr;
    logic [3:0]      r_wr_addr;
    logic [7:0]      r_wr_data;
    logic            r_wr_req;
    logic            r_busy;
    logic            r_err;
    logic [TmoW-1:0] r_tmo;

    logic            r_edit_prev;
    logic            r_next_prev;
    logic            r_up_prev;
    logic            r_down_prev;

    logic            w_edit_edge;
    logic            w_next_edge;
    logic            w_up_edge;
    logic            w_down_edge;
    logic            w_step_up;
    logic            w_step_down;

    assign w_edit_edge = edit_i & ~r_edit_prev;
    assign w_next_edge = next_i & ~r_next_prev;
    assign w_up_edge   = up_i   & ~r_up_prev;
    assign w_down_edge = down_i & ~r_down_prev;

    // Previous button levels for rising-edge detection
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_edit_prev <= 1'b0;
            r_next_prev <= 1'b0;
            r_up_prev   <= 1'b0;
            r_down_prev <= 1'b0;
        end else begin
            r_edit_prev <= edit_i;
            r_next_prev <= next_i;
            r_up_prev   <= up_i;
            r_down_prev <= down_i;
        end
    end

`ifdef AUTO_REPEAT_EN
    localparam int unsigned RptW = (REPEAT_DLY < 1) ? 1 : $clog2(REPEAT_DLY + 1);

    logic [RptW-1:0] r_rpt_cnt;
    logic            w_one_held;
    logic            w_rpt_armed;
    logic            w_rpt_fire;

    // Exactly one of up/down held, with no fresh edge stealing the cycle
    assign w_one_held  = (up_i ^ down_i) & ~w_up_edge & ~w_down_edge;
    assign w_rpt_armed = (r_rpt_cnt == RptW'(REPEAT_DLY));
    assign w_rpt_fire  = (r_state == StEdit) & w_one_held & tick_i & w_rpt_armed;

    // Count hold ticks up to REPEAT_DLY, then stay armed until release
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_rpt_cnt <= '0;
        end else if (r_state != StEdit || !w_one_held) begin
            r_rpt_cnt <= '0;
        end else if (tick_i && !w_rpt_armed) begin
            r_rpt_cnt <= r_rpt_cnt + RptW'(1);
        end
    end

    // Step requests from edges or from an armed repeat tick
    always_comb begin
        w_step_up   = 1'b0;
        w_step_down = 1'b0;
        if (w_up_edge && !w_down_edge) begin
            w_step_up = 1'b1;
        end else if (w_down_edge && !w_up_edge) begin
            w_step_down = 1'b1;
        end else if (w_rpt_fire) begin
            w_step_up   = up_i;
            w_step_down = down_i;
        end
    end
`else
    // Repeat strobe and delay have no effect in this build
    logic w_unused_tick;
    assign w_unused_tick = tick_i & (REPEAT_DLY != 0);

    // Step requests from single-button edges only
    always_comb begin
        w_step_up   = 1'b0;
        w_step_down = 1'b0;
        if (w_up_edge && !w_down_edge) begin
            w_step_up = 1'b1;
        end else if (w_down_edge && !w_up_edge) begin
            w_step_down = 1'b1;
        end
    end
`endif

    // Main sequencer FSM with registered outputs
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state   <= StIdle;
            r_field   <= 4'd0;
            r_value   <= 8'h00;
            r_rd_addr <= 4'd0;
            r_wr_addr <= 4'd0;
            r_wr_data <= 8'h00;
            r_wr_req  <= 1'b0;
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
            r_tmo     <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    r_field   <= 4'd0;
                    r_value   <= 8'h00;
                    r_rd_addr <= 4'd0;
                    r_busy    <= 1'b0;
                    if (w_edit_edge) begin
                        r_err     <= 1'b0;
                        r_field   <= 4'd1;
                        r_rd_addr <= 4'd1;
                        r_busy    <= 1'b1;
                        r_state   <= StLoad;
                    end
                end

                // rd_data_i is valid for rd_addr_o one cycle after it changed
                StLoad: begin
                    r_value <= sanitize(rd_data_i, r_field);
                    r_state <= StEdit;
                end

                StEdit: begin
                    if (w_edit_edge) begin
                        r_field   <= 4'd0;
                        r_value   <= 8'h00;
                        r_rd_addr <= 4'd0;
                        r_busy    <= 1'b0;
                        r_state   <= StIdle;
                    end else if (w_next_edge) begin
                        r_state <= StWrite;
                    end else if (w_step_up) begin
                        r_value <= bcd_inc(r_value, r_field);
                    end else if (w_step_down) begin
                        r_value <= bcd_dec(r_value, r_field);
                    end
                end

                StWrite: begin
                    r_wr_req  <= 1'b1;
                    r_wr_addr <= r_field;
                    r_wr_data <= r_value;
                    r_tmo     <= '0;
                    r_state   <= StWaitAck;
                end

                StWaitAck: begin
                    if (wr_ack_i && r_wr_req) begin
                        r_wr_req <= 1'b0;
                        if (r_field == LastField) begin
                            r_field   <= 4'd0;
                            r_value   <= 8'h00;
                            r_rd_addr <= 4'd0;
                            r_busy    <= 1'b0;
                            r_state   <= StIdle;
                        end else begin
                            r_field   <= r_field + 4'd1;
                            r_rd_addr <= r_field + 4'd1;
                            r_state   <= StLoad;
                        end
                    end else if (r_tmo == TmoW'(ACK_TIMEOUT - 1)) begin
                        // Give up on the bank; user may retry from the same field
                        r_wr_req <= 1'b0;
                        r_err    <= 1'b1;
                        r_state  <= StEdit;
                    end else begin
                        r_tmo <= r_tmo + TmoW'(1);
                    end
                end

                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign field_o   = r_field;
    assign value_o   = r_value;
    assign rd_addr_o = r_rd_addr;
    assign wr_addr_o = r_wr_addr;
    assign wr_data_o = r_wr_data;
    assign wr_req_o  = r_wr_req;
    assign busy_o    = r_busy;
    assign err_o     = r_err;

endmodule

// File: tb/tb_rtc_edit_sequencer.sv
// Directed self-checking bench for rtc_edit_sequencer.
// Auto-repeat expectations follow the AUTO_REPEAT_EN macro of the build.
module tb_rtc_edit_sequencer;

    logic       clk_i = 1'b0;
    logic       rst_n_i = 1'b0;
    logic       edit_i = 1'b0;
    logic       next_i = 1'b0;
    logic       up_i = 1'b0;
    logic       down_i = 1'b0;
    logic       tick_i = 1'b0;
    logic [7:0] rd_data_i = 8'h00;
    logic       wr_ack_i = 1'b0;
    logic [3:0] field_o;
    logic [7:0] value_o;
    logic [3:0] rd_addr_o;
    logic [3:0] wr_addr_o;
    logic [7:0] wr_data_o;
    logic       wr_req_o;
    logic       busy_o;
    logic       err_o;

    int total = 0;
    int bad = 0;

    rtc_edit_sequencer dut (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .edit_i    (edit_i),
        .next_i    (next_i),
        .up_i      (up_i),
        .down_i    (down_i),
        .tick_i    (tick_i),
        .rd_data_i (rd_data_i),
        .wr_ack_i  (wr_ack_i),
        .field_o   (field_o),
        .value_o   (value_o),
        .rd_addr_o (rd_addr_o),
        .wr_addr_o (wr_addr_o),
        .wr_data_o (wr_data_o),
        .wr_req_o  (wr_req_o),
        .busy_o    (busy_o),
        .err_o     (err_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic press_edit();
        edit_i = 1'b1; step(); edit_i = 1'b0; step();
    endtask

    task automatic press_up();
        up_i = 1'b1; step(); up_i = 1'b0; step();
    endtask

    task automatic press_down();
        down_i = 1'b1; step(); down_i = 1'b0; step();
    endtask

    // From EDIT: write with immediate ack, then land in EDIT of the next field
    task automatic advance();
        next_i = 1'b1; step(); next_i = 1'b0; step();
        wr_ack_i = 1'b1; step(); wr_ack_i = 1'b0; step();
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0;
        step(); step();
        total++; if (field_o !== 4'd0) begin bad++; $display("FAIL rst_field got=%h exp=0", field_o); end
        total++; if (value_o !== 8'h00) begin bad++; $display("FAIL rst_value got=%h exp=00", value_o); end
        total++; if (wr_req_o !== 1'b0) begin bad++; $display("FAIL rst_wr_req got=%b exp=0", wr_req_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy_o); end
        total++; if (err_o !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", err_o); end
        total++; if ({rd_addr_o, wr_addr_o, wr_data_o} !== 16'h0000) begin
            bad++; $display("FAIL rst_addr got=%h exp=0000", {rd_addr_o, wr_addr_o, wr_data_o});
        end
        rst_n_i = 1'b1;
        step();
    endtask

    task automatic test_idle_ignore();
        up_i = 1'b1; step(); up_i = 1'b0; step();
        next_i = 1'b1; step(); next_i = 1'b0; step();
        down_i = 1'b1; step(); down_i = 1'b0; step();
        total++; if (field_o !== 4'd0 || busy_o !== 1'b0) begin
            bad++; $display("FAIL idle_ignore field=%h busy=%b exp 0/0", field_o, busy_o);
        end
        total++; if (value_o !== 8'h00 || wr_req_o !== 1'b0) begin
            bad++; $display("FAIL idle_value value=%h req=%b exp 00/0", value_o, wr_req_o);
        end
    endtask

    task automatic test_basic();
        rd_data_i = 8'h58;
        edit_i = 1'b1; step(); edit_i = 1'b0;
        total++; if (field_o !== 4'd1 || rd_addr_o !== 4'd1 || busy_o !== 1'b1) begin
            bad++; $display("FAIL load_entry field=%h rd=%h busy=%b exp 1/1/1", field_o, rd_addr_o, busy_o);
        end
        step();
        total++; if (value_o !== 8'h58) begin bad++; $display("FAIL load_value got=%h exp=58", value_o); end
        press_up();
        total++; if (value_o !== 8'h59) begin bad++; $display("FAIL up_59 got=%h exp=59", value_o); end
        press_up();
        total++; if (value_o !== 8'h00) begin bad++; $display("FAIL up_wrap got=%h exp=00", value_o); end
        next_i = 1'b1; step(); next_i = 1'b0;
        total++; if (wr_req_o !== 1'b0) begin bad++; $display("FAIL write_early got=%b exp=0", wr_req_o); end
        step();
        total++; if (wr_req_o !== 1'b1 || wr_addr_o !== 4'd1 || wr_data_o !== 8'h00) begin
            bad++; $display("FAIL write_req req=%b addr=%h data=%h exp 1/1/00", wr_req_o, wr_addr_o, wr_data_o);
        end
        step();
        total++; if (wr_req_o !== 1'b1 || wr_data_o !== 8'h00) begin
            bad++; $display("FAIL write_hold req=%b data=%h exp 1/00", wr_req_o, wr_data_o);
        end
        wr_ack_i = 1'b1; step(); wr_ack_i = 1'b0;
        total++; if (wr_req_o !== 1'b0 || field_o !== 4'd2 || rd_addr_o !== 4'd2) begin
            bad++; $display("FAIL ack_adv req=%b field=%h rd=%h exp 0/2/2", wr_req_o, field_o, rd_addr_o);
        end
        step();
        press_edit();
        total++; if (field_o !== 4'd0 || busy_o !== 1'b0 || wr_req_o !== 1'b0) begin
            bad++; $display("FAIL abort field=%h busy=%b req=%b exp 0/0/0", field_o, busy_o, wr_req_o);
        end
    endtask

    task automatic test_bcd_carry();
        rd_data_i = 8'h10;
        press_edit();
        press_down();
        total++; if (value_o !== 8'h09) begin bad++; $display("FAIL borrow got=%h exp=09", value_o); end
        press_up();
        total++; if (value_o !== 8'h10) begin bad++; $display("FAIL carry got=%h exp=10", value_o); end
        up_i = 1'b1; down_i = 1'b1; step(); up_i = 1'b0; down_i = 1'b0; step();
        total++; if (value_o !== 8'h10) begin bad++; $display("FAIL up_down_same got=%h exp=10", value_o); end
        next_i = 1'b1; up_i = 1'b1; step(); next_i = 1'b0; up_i = 1'b0; step();
        total++; if (wr_req_o !== 1'b1 || wr_data_o !== 8'h10) begin
            bad++; $display("FAIL next_priority req=%b data=%h exp 1/10", wr_req_o, wr_data_o);
        end
        wr_ack_i = 1'b1; step(); wr_ack_i = 1'b0; step();
        press_edit();
    endtask

    task automatic test_field4();
        rd_data_i = 8'h01;
        press_edit();
        advance(); advance(); advance();
        total++; if (field_o !== 4'd4 || value_o !== 8'h01) begin
            bad++; $display("FAIL f4_load field=%h value=%h exp 4/01", field_o, value_o);
        end
        press_down();
        total++; if (value_o !== 8'h31) begin bad++; $display("FAIL f4_down_wrap got=%h exp=31", value_o); end
        press_up();
        total++; if (value_o !== 8'h01) begin bad++; $display("FAIL f4_up_wrap got=%h exp=01", value_o); end
        press_edit();
        press_edit();
        advance(); advance();
        rd_data_i = 8'h3A;
        advance();
        total++; if (field_o !== 4'd4 || value_o !== 8'h01) begin
            bad++; $display("FAIL f4_nonbcd field=%h value=%h exp 4/01", field_o, value_o);
        end
        rd_data_i = 8'h13;
        advance();
        total++; if (field_o !== 4'd5 || value_o !== 8'h01) begin
            bad++; $display("FAIL f5_range field=%h value=%h exp 5/01", field_o, value_o);
        end
        press_edit();
    endtask

    task automatic test_walk();
        int nwr;
        nwr = 0;
        rd_data_i = 8'h05;
        press_edit();
        for (int f = 1; f <= 9; f++) begin
            total++; if (field_o !== f[3:0]) begin
                bad++; $display("FAIL walk_field got=%h exp=%h", field_o, f[3:0]);
            end
            next_i = 1'b1; step(); next_i = 1'b0; step();
            total++; if (wr_req_o !== 1'b1 || wr_addr_o !== f[3:0] || wr_data_o !== 8'h05) begin
                bad++; $display("FAIL walk_write req=%b addr=%h data=%h exp 1/%h/05",
                                wr_req_o, wr_addr_o, wr_data_o, f[3:0]);
            end
            if (wr_req_o === 1'b1) nwr++;
            wr_ack_i = 1'b1; step(); wr_ack_i = 1'b0;
            if (f < 9) step();
        end
        total++; if (nwr != 9) begin bad++; $display("FAIL walk_count got=%0d exp=9", nwr); end
        total++; if (field_o !== 4'd0 || busy_o !== 1'b0 || wr_req_o !== 1'b0) begin
            bad++; $display("FAIL walk_end field=%h busy=%b req=%b exp 0/0/0", field_o, busy_o, wr_req_o);
        end
        step();
    endtask

    task automatic test_timeout();
        int hi;
        rd_data_i = 8'h05;
        press_edit();
        next_i = 1'b1; step(); next_i = 1'b0; step();
        hi = (wr_req_o === 1'b1) ? 1 : 0;
        for (int k = 0; k < 300; k++) begin
            step();
            if (wr_req_o === 1'b1) hi++;
            else break;
        end
        total++; if (hi != 255) begin bad++; $display("FAIL tmo_len got=%0d exp=255", hi); end
        total++; if (err_o !== 1'b1 || field_o !== 4'd1 || busy_o !== 1'b1) begin
            bad++; $display("FAIL tmo_state err=%b field=%h busy=%b exp 1/1/1", err_o, field_o, busy_o);
        end
        press_up();
        total++; if (value_o !== 8'h06) begin bad++; $display("FAIL tmo_edit got=%h exp=06", value_o); end
        wr_ack_i = 1'b1; step(); wr_ack_i = 1'b0; step();
        total++; if (field_o !== 4'd1 || wr_req_o !== 1'b0) begin
            bad++; $display("FAIL stray_ack field=%h req=%b exp 1/0", field_o, wr_req_o);
        end
        press_edit();
        total++; if (err_o !== 1'b1 || busy_o !== 1'b0) begin
            bad++; $display("FAIL err_sticky err=%b busy=%b exp 1/0", err_o, busy_o);
        end
        edit_i = 1'b1; step(); edit_i = 1'b0;
        total++; if (err_o !== 1'b0) begin bad++; $display("FAIL err_clear got=%b exp=0", err_o); end
        step();
        press_edit();
    endtask

    task automatic test_reset_wait_ack();
        rd_data_i = 8'h05;
        press_edit();
        next_i = 1'b1; step(); next_i = 1'b0; step();
        total++; if (wr_req_o !== 1'b1) begin bad++; $display("FAIL pre_rst_req got=%b exp=1", wr_req_o); end
        #1 rst_n_i = 1'b0;
        #1;
        total++; if (wr_req_o !== 1'b0 || busy_o !== 1'b0 || field_o !== 4'd0) begin
            bad++; $display("FAIL async_rst req=%b busy=%b field=%h exp 0/0/0", wr_req_o, busy_o, field_o);
        end
        #1 rst_n_i = 1'b1;
        step();
        edit_i = 1'b1; step(); edit_i = 1'b0;
        total++; if (field_o !== 4'd1 || busy_o !== 1'b1) begin
            bad++; $display("FAIL resume field=%h busy=%b exp 1/1", field_o, busy_o);
        end
        step();
        press_edit();
    endtask

    task automatic test_repeat();
        logic [7:0] exp_v;
        rd_data_i = 8'h20;
        press_edit();
        advance(); advance();
        total++; if (field_o !== 4'd3 || value_o !== 8'h20) begin
            bad++; $display("FAIL rpt_start field=%h value=%h exp 3/20", field_o, value_o);
        end
        up_i = 1'b1; step();
        total++; if (value_o !== 8'h21) begin bad++; $display("FAIL rpt_edge got=%h exp=21", value_o); end
        for (int t = 1; t <= 7; t++) begin
            tick_i = 1'b1; step(); tick_i = 1'b0; step();
`ifdef AUTO_REPEAT_EN
            case (t)
                5:       exp_v = 8'h22;
                6:       exp_v = 8'h23;
                7:       exp_v = 8'h00;
                default: exp_v = 8'h21;
            endcase
`else
            exp_v = 8'h21;
`endif
            total++; if (value_o !== exp_v) begin
                bad++; $display("FAIL rpt_tick%0d got=%h exp=%h", t, value_o, exp_v);
            end
        end
        up_i = 1'b0; step();
        exp_v = value_o;
        up_i = 1'b1; down_i = 1'b1; step();
        for (int t = 1; t <= 7; t++) begin
            tick_i = 1'b1; step(); tick_i = 1'b0; step();
        end
        total++; if (value_o !== exp_v) begin
            bad++; $display("FAIL rpt_both got=%h exp=%h", value_o, exp_v);
        end
        up_i = 1'b0; down_i = 1'b0; step();
        press_edit();
    endtask

    initial begin
        test_reset();
        test_idle_ignore();
        test_basic();
        test_bcd_carry();
        test_field4();
        test_walk();
        test_timeout();
        test_reset_wait_ack();
        test_repeat();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
